reg_writeback: RTL and testbench

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/reg_writeback.sv | 151 +++++++++++++++
 tb/tb_reg_writeback.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// Register-file writeback: ALU results win, loads wait in a 4-entry FIFO with WAW kill; write port is registered (1 cycle), mem_ready drops only when the FIFO is full.
// Optional bypass/forwarding read port enabled by defining WB_BYPASS_EN.
module reg_writeback (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3,
  output logic [2:0]  pend_cnt
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]  byp_a,
  output logic        byp_hit,
  output logic [31:0] byp_data
`endif
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] dat;
    logic        kill;
  } ent_t;

  ent_t        ent_q [4];
  ent_t        ent_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we3_q, we3_d;
  logic [4:0]  a3_q, a3_d;
  logic [31:0] wd3_q, wd3_d;

  logic        alu_wr;
  logic        push;
  logic        pop;
  logic [3:0]  ent_vld;
  ent_t        head;

  // Ready depends only on the registered count, so a same-cycle pop never makes room.
  assign mem_ready = (cnt_q != 3'd4);
  assign alu_wr    = alu_valid && (alu_rd != 5'd0);
  assign push      = mem_valid && mem_ready && (mem_rd != 5'd0);
  assign pop       = !alu_wr && (cnt_q != 3'd0);
  assign head      = ent_q[rd_ptr_q];

  assign we3      = we3_q;
  assign a3       = a3_q;
  assign wd3      = wd3_q;
  assign pend_cnt = cnt_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ent_vld[i] = ({1'b0, 2'(2'(i) - rd_ptr_q)} < cnt_q);
    end
  end

  always_comb begin
    ent_d    = ent_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    we3_d    = 1'b0;
    a3_d     = 5'd0;
    wd3_d    = 32'd0;

    // An ALU write is younger than every queued load to the same register.
    for (int i = 0; i < 4; i++) begin
      if (alu_wr && ent_vld[i] && (ent_q[i].rd == alu_rd)) begin
        ent_d[i].kill = 1'b1;
      end
    end

    if (push) begin
      ent_d[wr_ptr_q] = '{rd: mem_rd, dat: mem_data, kill: 1'b0};
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase

    if (alu_wr) begin
      we3_d = 1'b1;
      a3_d  = alu_rd;
      wd3_d = alu_data;
    end else if (pop && !head.kill) begin
      we3_d = 1'b1;
      a3_d  = head.rd;
      wd3_d = head.dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        ent_q[i] <= '0;
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
      we3_q    <= 1'b0;
      a3_q     <= 5'd0;
      wd3_q    <= 32'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        ent_q[i] <= ent_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      we3_q    <= we3_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
    end
  end

`ifdef WB_BYPASS_EN
  // Scan from the output register through the FIFO oldest-to-youngest; the last match wins.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = 32'd0;
    if (byp_a != 5'd0) begin
      if (we3_q && (a3_q == byp_a)) begin
        byp_hit  = 1'b1;
        byp_data = wd3_q;
      end
      for (int k = 0; k < 4; k++) begin
        if ((3'(k) < cnt_q) && !ent_q[2'(rd_ptr_q + 2'(k))].kill &&
            (ent_q[2'(rd_ptr_q + 2'(k))].rd == byp_a)) begin
          byp_hit  = 1'b1;
          byp_data = ent_q[2'(rd_ptr_q + 2'(k))].dat;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: expected writes queued at stimulus time, checked as we3 fires.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [2:0]  pend_cnt;
`ifdef WB_BYPASS_EN
  logic [4:0]  byp_a;
  logic        byp_hit;
  logic [31:0] byp_data;
`endif

  reg_writeback dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .we3       (we3),
    .a3        (a3),
    .wd3       (wd3),
    .pend_cnt  (pend_cnt)
`ifdef WB_BYPASS_EN
    ,
    .byp_a     (byp_a),
    .byp_hit   (byp_hit),
    .byp_data  (byp_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  int          vectors     = 0;
  int          miscompares = 0;
  wr_t         exp_q[$];
  logic [31:0] arch [32];

  function automatic wr_t mk(input logic [4:0] a, input logic [31:0] d);
    wr_t r;
    r.a = a;
    r.d = d;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 12 && pend_cnt != 3'd0; n++) step();
    step();
    step();
    chk("drain_pend_cnt", 64'(pend_cnt), 64'd0);
    chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Every register-file write must match the head of the expected queue.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (we3 === 1'b1) begin
      chk("a3_nonzero", 64'(a3 != 5'd0), 64'd1);
      chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wb_addr", 64'(a3), 64'(e.a));
        chk("wb_data", 64'(wd3), 64'(e.d));
      end
      arch[a3] = wd3;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         k;
    logic       hs;
    logic [2:0] cnt_before;

    rst_n     = 1'b0;
    alu_valid = 1'b0;
    alu_rd    = 5'd0;
    alu_data  = 32'd0;
    mem_valid = 1'b0;
    mem_rd    = 5'd0;
    mem_data  = 32'd0;
`ifdef WB_BYPASS_EN
    byp_a     = 5'd0;
`endif
    for (int i = 0; i < 32; i++) arch[i] = 32'd0;

    // Reset state
    #3;
    chk("rst_we3", 64'(we3), 64'd0);
    chk("rst_a3", 64'(a3), 64'd0);
    chk("rst_wd3", 64'(wd3), 64'd0);
    chk("rst_pend_cnt", 64'(pend_cnt), 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_mem_ready", 64'(mem_ready), 64'd1);

    // ALU-only write, one-cycle latency
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    exp_q.push_back(mk(5'd5, 32'hDEADBEEF));
    step();
    idle();
    chk("alu_we3", 64'(we3), 64'd1);
    chk("alu_a3", 64'(a3), 64'd5);
    chk("alu_wd3", 64'(wd3), 64'hDEADBEEF);
    chk("alu_pend_cnt", 64'(pend_cnt), 64'd0);
    step();
    chk("alu_we3_drop", 64'(we3), 64'd0);

    // Five loads against a busy ALU: fill to 4, stall, then drain in order
    for (int c = 0; c < 6; c++) exp_q.push_back(mk(5'd7, 32'(32'h700 + c)));
    for (int j = 1; j <= 5; j++) exp_q.push_back(mk(5'(j), 32'(32'h100 + j)));
    k = 1;
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'(32'h700 + c);
      mem_valid = (k <= 5); mem_rd = 5'(k); mem_data = 32'(32'h100 + k);
      hs = mem_valid && mem_ready;
      step();
      if (hs) k++;
      if (c == 3) begin
        chk("full_pend_cnt", 64'(pend_cnt), 64'd4);
        chk("full_mem_ready", 64'(mem_ready), 64'd0);
      end
    end
    chk("stalled_load_index", 64'(k), 64'd5);
    alu_valid = 1'b0;
    for (int n = 0; n < 10 && k <= 5; n++) begin
      mem_valid = 1'b1; mem_rd = 5'(k); mem_data = 32'(32'h100 + k);
      hs = mem_ready;
      cnt_before = pend_cnt;
      step();
      if (hs) begin
        k++;
        chk("pushpop_pend_cnt", 64'(pend_cnt), 64'(cnt_before));
      end
    end
    chk("rd5_accepted", 64'(k), 64'd6);
    idle();
    drain();

    // WAW: queued load to r9 killed by a later ALU write to r9
    exp_q.push_back(mk(5'd10, 32'h33));
    exp_q.push_back(mk(5'd9, 32'h22));
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h33;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h11;
    step();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h22;
    mem_valid = 1'b0;
    step();
    chk("waw_pend_cnt", 64'(pend_cnt), 64'd1);
    idle();
    step();
    chk("killed_pop_we3", 64'(we3), 64'd0);
    chk("killed_pop_pend_cnt", 64'(pend_cnt), 64'd0);
    step();
    chk("waw_final_r9", 64'(arch[9]), 64'h22);

    // Load pushed alongside a matching ALU write is younger and survives
    exp_q.push_back(mk(5'd12, 32'h44));
    exp_q.push_back(mk(5'd12, 32'h55));
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h44;
    mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'h55;
    step();
    idle();
    step();
    chk("young_load_we3", 64'(we3), 64'd1);
    chk("young_load_wd3", 64'(wd3), 64'h55);
    drain();

    // Register 0 is never written, loads to r0 are dropped
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'(32'hBAD0 + c);
      mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'(32'hBAD8 + c);
      step();
      chk("r0_we3", 64'(we3), 64'd0);
      chk("r0_pend_cnt", 64'(pend_cnt), 64'd0);
    end
    idle();
    step();
    chk("r0_after_we3", 64'(we3), 64'd0);

    // Reset mid-operation with three loads queued
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back(mk(5'd20, 32'(32'h900 + c)));
      alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'(32'h900 + c);
      mem_valid = 1'b1; mem_rd = 5'(21 + c); mem_data = 32'(32'hA00 + c);
      step();
    end
    idle();
    #5;
    chk("pre_rst_pend_cnt", 64'(pend_cnt), 64'd3);
    chk("pre_rst_sb_empty", 64'(exp_q.size()), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we3", 64'(we3), 64'd0);
    chk("mid_rst_a3", 64'(a3), 64'd0);
    chk("mid_rst_pend_cnt", 64'(pend_cnt), 64'd0);
    chk("mid_rst_mem_ready", 64'(mem_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      chk("post_rst_no_write", 64'(we3), 64'd0);
    end
    chk("post_rst_pend_cnt", 64'(pend_cnt), 64'd0);

`ifdef WB_BYPASS_EN
    // Forwarding returns the youngest matching entry
    exp_q.push_back(mk(5'd4, 32'h40));
    exp_q.push_back(mk(5'd4, 32'h41));
    exp_q.push_back(mk(5'd3, 32'hA));
    exp_q.push_back(mk(5'd3, 32'hB));
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h40;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hA;
    step();
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h41;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hB;
    step();
    idle();
    byp_a = 5'd3;
    #1;
    chk("byp3_hit", 64'(byp_hit), 64'd1);
    chk("byp3_data", 64'(byp_data), 64'hB);
    byp_a = 5'd4;
    #1;
    chk("byp4_hit", 64'(byp_hit), 64'd1);
    chk("byp4_data", 64'(byp_data), 64'h41);
    byp_a = 5'd0;
    #1;
    chk("byp0_hit", 64'(byp_hit), 64'd0);
    drain();
`endif

    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
